alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Micro-sequencer that drives the 4-bit ALU + 8-bit result-register datapath (Data, Function, registered ALUout with low-nibble feedback) through a short stored program. Software loads up to DEPTH (data, function) steps, pulses start, and receives the final register value with a done pulse. Sits directly in front of the datapath: owns its Data/Function inputs and its clear, and observes its ALUout.

Parameters:
DEPTH, 8, number of program slots (power of two, 2..16)
ADDR_W, 3, log2(DEPTH)

Ports:
Clock  in  1  system clock, all state updates on posedge
Reset_b  in  1  synchronous, active-high reset (1 = reset)
prog_we  in  1  write enable for program slot
prog_addr  in  ADDR_W  slot being written
prog_data  in  4  operand A for the slot
prog_func  in  2  function code for the slot (00 add, 01 mul, 10 shift, 11 hold)
prog_len  in  ADDR_W+1  steps to run, sampled on accepted start
start  in  1  request to run program
abort  in  1  stop current run
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle pulse, result valid
result  out  8  captured final datapath value
alu_data  out  4  drives datapath Data
alu_function  out  2  drives datapath Function
alu_clear  out  1  drives datapath reset (active-high, synchronous)
alu_result  in  8  datapath registered ALUout

Behaviour:
- Reset (Reset_b=1 at edge): state IDLE; busy=0, done=0, result=0, alu_data=0, alu_function=2'b11, alu_clear=0, pc=0; all program slots become data=0, func=11. Reset mid-run abandons the run, no done.
- Outputs alu_data/alu_function/alu_clear are registered.
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE: alu_function=11 (datapath holds), alu_data=0. start=1 and prog_len!=0 -> latch len=min(prog_len, DEPTH), pc=0, busy=1, go CLEAR. start with prog_len=0 ignored.
- CLEAR: alu_clear=1 for exactly one cycle; datapath register becomes 0. Next RUN.
- RUN: drive slot[pc]; alu_clear=0. Datapath captures at end of the cycle. pc==len-1 -> CAPTURE, else pc+1. One step per cycle, no stalls.
- CAPTURE: alu_function=11; result<=alu_result (value after last step); done=1 next cycle with busy=0, back to IDLE.
- Latency: start accepted at edge k -> done high in cycle k+len+3 (CLEAR, len RUN, CAPTURE, done cycle). result stable until next done or reset.
- Programming: prog_we honoured only in IDLE; ignored while busy. prog_we and start in the same IDLE cycle: write lands, run uses the new slot.
- start while busy ignored.
- abort (any non-IDLE state): next state IDLE, busy=0, no done, result unchanged, alu_function=11. abort in IDLE no effect. abort and Reset_b together: reset wins.
- Arithmetic lives entirely in the datapath; the sequencer never modifies alu_result.

Decomposition:
- Shared package: function codes FN_ADD=2'b00, FN_MUL=2'b01, FN_SHL=2'b10, FN_HOLD=2'b11; state encoding constants.
- One natural sub-module: alu_prog_mem (DEPTH x 6-bit, synchronous write, reset-to-hold, combinational read).

Test Plan (bench instantiates the sequencer with the existing datapath):
- Program {00,3},{01,5},{10,1},{11,0}, len=4, start -> done at k+7, result=30 (0->3->15->30->30).
- Single step {00,9}, len=1 -> done at k+4, result=9; repeat start -> identical result=9 (CLEAR verified).
- abort asserted in second RUN cycle of the 4-step program -> busy=0 next cycle, done never pulses, result keeps previous 30.
- prog_len=0 start -> busy stays 0; prog_len=15 with DEPTH=8 -> exactly 8 RUN cycles, done at k+11.
- prog_we to slot 0 while busy -> slot unchanged; rerun gives original result.
- Reset_b=1 mid-RUN -> next cycle busy=0, result=0, alu_function=11, slots read hold/0.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: definitions shared by the sequencer and its program store.
//   - datapath function codes
//   - sequencer state encoding
//   - program step record and the value of an empty slot
package alu_sequencer_pkg;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_MUL  = 2'b01;
  localparam logic [1:0] FN_SHL  = 2'b10;
  localparam logic [1:0] FN_HOLD = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLEAR   = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  typedef struct packed {
    logic [1:0] func;
    logic [3:0] data;
  } step_t;

  // An empty slot leaves the datapath register untouched.
  localparam step_t STEP_HOLD = '{func: FN_HOLD, data: 4'd0};

endpackage

// File: rtl/alu_sequencer_prog_mem.sv
// alu_prog_mem: DEPTH-entry program store, one step_t per slot.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset, every slot becomes STEP_HOLD
//   i_we     write strobe (already qualified by the sequencer)
//   i_waddr  slot written
//   i_wstep  step written
//   i_raddr  slot read
//   o_rstep  combinational read data
module alu_prog_mem
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  step_t             i_wstep,
  input  logic [ADDR_W-1:0] i_raddr,
  output step_t             o_rstep
);

  step_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= STEP_HOLD;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wstep;
    end
  end

  assign o_rstep = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs a stored (data, function) program through the external
// 4-bit ALU / 8-bit result-register datapath and returns its final value.
// Ports:
//   Clock, Reset_b      clock and synchronous active-high reset
//   prog_we/addr/data/func  program slot write (honoured only while idle)
//   prog_len            number of steps, sampled when start is accepted
//   start, abort        run request / cancel
//   busy, done, result  run status, one-cycle completion pulse, final value
//   alu_data, alu_function, alu_clear  registered datapath controls
//   alu_result          datapath registered ALUout
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [3:0]        prog_data,
  input  logic [1:0]        prog_func,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic [3:0]        alu_data,
  output logic [1:0]        alu_function,
  output logic              alu_clear,
  input  logic [7:0]        alu_result
);

  localparam int LEN_W = ADDR_W + 1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [LEN_W-1:0]  r_len;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_result;
  logic [3:0]        r_alu_data;
  logic [1:0]        r_alu_function;
  logic              r_alu_clear;

  logic              w_we;
  logic [ADDR_W-1:0] w_raddr;
  step_t             w_step;
  logic              w_last;
  logic [LEN_W-1:0]  w_len_m1;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    return (n > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : n;
  endfunction

  // Writes only land while idle, so a running program cannot be altered.
  assign w_we = prog_we && (r_state == ST_IDLE);

  // Outputs are registered, so in RUN we fetch the step for the next cycle.
  assign w_raddr  = (r_state == ST_RUN) ? r_pc + ADDR_W'(1) : r_pc;
  assign w_len_m1 = r_len - LEN_W'(1);
  assign w_last   = ({1'b0, r_pc} == w_len_m1);

  alu_prog_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_prog_mem (
    .i_clk  (Clock),
    .i_rst  (Reset_b),
    .i_we   (w_we),
    .i_waddr(prog_addr),
    .i_wstep('{func: prog_func, data: prog_data}),
    .i_raddr(w_raddr),
    .o_rstep(w_step)
  );

  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_len          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_alu_data     <= '0;
      r_alu_function <= FN_HOLD;
      r_alu_clear    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && abort) begin
        r_state        <= ST_IDLE;
        r_busy         <= 1'b0;
        r_alu_data     <= '0;
        r_alu_function <= FN_HOLD;
        r_alu_clear    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_alu_data     <= '0;
            r_alu_function <= FN_HOLD;
            r_alu_clear    <= 1'b0;
            if (start && (prog_len != '0)) begin
              r_len       <= clamp_len(prog_len);
              r_pc        <= '0;
              r_busy      <= 1'b1;
              r_alu_clear <= 1'b1;
              r_state     <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            r_alu_clear    <= 1'b0;
            r_alu_data     <= w_step.data;
            r_alu_function <= w_step.func;
            r_state        <= ST_RUN;
          end
          ST_RUN: begin
            if (w_last) begin
              r_alu_data     <= '0;
              r_alu_function <= FN_HOLD;
              r_state        <= ST_CAPTURE;
            end else begin
              r_pc           <= r_pc + ADDR_W'(1);
              r_alu_data     <= w_step.data;
              r_alu_function <= w_step.func;
            end
          end
          default: begin
            // CAPTURE: the datapath now holds the value after the last step.
            r_result <= alu_result;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign alu_data     = r_alu_data;
  assign alu_function = r_alu_function;
  assign alu_clear    = r_alu_clear;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: sequencer plus a behavioural ALU/register datapath,
// checked every cycle against a transaction-level model of a run.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic        Clock = 1'b0;
  logic        Reset_b;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [3:0]  prog_data;
  logic [1:0]  prog_func;
  logic [3:0]  prog_len;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic [3:0]  alu_data;
  logic [1:0]  alu_function;
  logic        alu_clear;
  logic [7:0]  alu_result;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  alu_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_func(prog_func), .prog_len(prog_len),
    .start(start), .abort(abort), .busy(busy), .done(done), .result(result),
    .alu_data(alu_data), .alu_function(alu_function), .alu_clear(alu_clear),
    .alu_result(alu_result)
  );

  // Datapath: A = Data, B = low nibble of the registered result.
  function automatic logic [7:0] alu_op(input logic [7:0] r, input logic [3:0] a,
                                        input logic [1:0] f);
    logic [3:0] b;
    b = r[3:0];
    case (f)
      2'b00:   return 8'(a) + 8'(b);
      2'b01:   return 8'(a) * 8'(b);
      2'b10:   return 8'(b) << a;
      default: return r;
    endcase
  endfunction

  logic [7:0] dp_reg = 8'd0;
  assign alu_result = dp_reg;
  always @(posedge Clock) begin
    if (alu_clear) dp_reg <= 8'd0;
    else           dp_reg <= alu_op(dp_reg, alu_data, alu_function);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] run_model(input logic [7:0][5:0] p, input int n);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < n; i++) r = alu_op(r, p[i][3:0], p[i][5:4]);
    return r;
  endfunction

  function automatic logic [7:0][5:0] apply_write(input logic [7:0][5:0] p, input logic we,
                                                  input logic [2:0] a, input logic [5:0] s);
    if (we) p[a] = s;
    return p;
  endfunction

  function automatic int clampn(input logic [3:0] n);
    return (n > 4'd8) ? 8 : int'(n);
  endfunction

  logic [7:0][5:0] m_prog, m_snap;
  logic            m_ok = 1'b0;
  logic            m_busy, m_done;
  logic [4:0]      m_cnt;   // edges left until the done edge
  logic [3:0]      m_len;
  logic [7:0]      m_res, m_pend;

  always @(posedge Clock) begin
    if (Reset_b) begin
      m_ok   <= 1'b1;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 8'd0;
      m_cnt  <= 5'd0;
      m_len  <= 4'd0;
      m_prog <= {8{6'b110000}};
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (prog_we) m_prog[prog_addr] <= {prog_func, prog_data};
        if (start && prog_len != 4'd0) begin
          m_busy <= 1'b1;
          m_len  <= 4'(clampn(prog_len));
          m_cnt  <= 5'(clampn(prog_len) + 2);
          m_snap <= apply_write(m_prog, prog_we, prog_addr, {prog_func, prog_data});
          m_pend <= run_model(apply_write(m_prog, prog_we, prog_addr, {prog_func, prog_data}),
                              clampn(prog_len));
        end
      end else if (abort) begin
        m_busy <= 1'b0;
      end else if (m_cnt == 5'd1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_cnt <= m_cnt - 5'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare; within a run, m_cnt == len+2 is the clear cycle,
  // 1 is the capture cycle and anything between is a step.
  always @(negedge Clock) begin
    if (m_ok) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("result", 32'(result), 32'(m_res));
      if (!m_busy) begin
        check("idle_fn", 32'(alu_function), 32'(FN_HOLD));
        check("idle_data", 32'(alu_data), 32'd0);
        check("idle_clr", 32'(alu_clear), 32'd0);
      end else if (m_cnt == 5'(m_len) + 5'd2) begin
        check("clear_clr", 32'(alu_clear), 32'd1);
        check("clear_fn", 32'(alu_function), 32'(FN_HOLD));
      end else if (m_cnt == 5'd1) begin
        check("cap_fn", 32'(alu_function), 32'(FN_HOLD));
        check("cap_clr", 32'(alu_clear), 32'd0);
      end else begin
        check("run_fn", 32'(alu_function), 32'(m_snap[3'(5'(m_len) + 5'd1 - m_cnt)][5:4]));
        check("run_data", 32'(alu_data), 32'(m_snap[3'(5'(m_len) + 5'd1 - m_cnt)][3:0]));
        check("run_clr", 32'(alu_clear), 32'd0);
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  task automatic write_slot(input int a, input logic [1:0] f, input logic [3:0] d);
    @(negedge Clock);
    prog_we = 1'b1; prog_addr = 3'(a); prog_func = f; prog_data = d;
    @(negedge Clock);
    prog_we = 1'b0;
  endtask

  // Returns at the falling edge just after the edge that samples start.
  task automatic start_run(input logic [3:0] len);
    @(negedge Clock);
    start = 1'b1; prog_len = len;
    @(negedge Clock);
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen; with start accepted at edge k
  // and called straight after start_run, done shows after edge k+len+2.
  task automatic wait_done(input int exp_edges, input string name,
                           output int add_cyc, output int act_cyc);
    int n;
    n = 0; add_cyc = 0; act_cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge Clock); #1;
      if (alu_function == FN_ADD) add_cyc++;
      if (alu_function != FN_HOLD) act_cyc++;
      if (done) begin n = i; break; end
    end
    if (n == 0) begin
      checks++; errors++;
      $display("FAIL %s done never seen, expected after %0d edges", name, exp_edges);
    end else begin
      check(name, 32'(n), 32'(exp_edges));
    end
  endtask

  initial begin
    int adds, acts, seen;
    logic [7:0][5:0] pin;
    Reset_b = 1'b1; prog_we = 0; prog_addr = 0; prog_data = 0; prog_func = 0;
    prog_len = 0; start = 0; abort = 0;
    repeat (2) @(negedge Clock);
    Reset_b = 1'b0;
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fn", 32'(alu_function), 32'(FN_HOLD));

    pin = {8{6'b110000}};
    pin[0] = {2'b00, 4'd3}; pin[1] = {2'b01, 4'd5}; pin[2] = {2'b10, 4'd1};
    check("model_pin", 32'(run_model(pin, 4)), 32'd30);

    // four-step program: 0 -> 3 -> 15 -> 30 -> 30
    write_slot(0, 2'b00, 4'd3); write_slot(1, 2'b01, 4'd5);
    write_slot(2, 2'b10, 4'd1); write_slot(3, 2'b11, 4'd0);
    start_run(4'd4);
    wait_done(6, "lat4", adds, acts);
    check("res4", 32'(result), 32'd30);

    // single step, run twice to confirm the clear
    write_slot(0, 2'b00, 4'd9);
    start_run(4'd1);
    wait_done(3, "lat1", adds, acts);
    check("res1a", 32'(result), 32'd9);
    start_run(4'd1);
    wait_done(3, "lat1b", adds, acts);
    check("res1b", 32'(result), 32'd9);

    write_slot(0, 2'b00, 4'd3);
    start_run(4'd4);
    wait_done(6, "lat4b", adds, acts);
    check("res4b", 32'(result), 32'd30);

    // abort in the second RUN cycle
    start_run(4'd4);
    @(negedge Clock);
    @(negedge Clock);
    abort = 1'b1;
    @(negedge Clock);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (10) begin @(negedge Clock); if (done) seen++; end
    check("abort_nodone", 32'(seen), 32'd0);
    check("abort_res", 32'(result), 32'd30);

    // zero-length start is ignored
    start_run(4'd0);
    check("len0_busy", 32'(busy), 32'd0);

    // length clamps to DEPTH
    for (int i = 0; i < 8; i++) write_slot(i, 2'b00, 4'd1);
    start_run(4'd15);
    wait_done(10, "lat15", adds, acts);
    check("len15_steps", 32'(adds), 32'd8);
    check("res15", 32'(result), 32'd8);

    // writes while busy are dropped
    write_slot(0, 2'b00, 4'd3); write_slot(1, 2'b01, 4'd5);
    write_slot(2, 2'b10, 4'd1); write_slot(3, 2'b11, 4'd0);
    start_run(4'd4);
    prog_we = 1'b1; prog_addr = 3'd0; prog_func = 2'b00; prog_data = 4'hF;
    @(negedge Clock);
    prog_we = 1'b0;
    wait_done(5, "lat_we", adds, acts);
    check("res_we", 32'(result), 32'd30);
    start_run(4'd4);
    wait_done(6, "lat_we2", adds, acts);
    check("res_we2", 32'(result), 32'd30);

    // reset mid-run
    start_run(4'd4);
    @(negedge Clock);
    Reset_b = 1'b1;
    @(negedge Clock);
    Reset_b = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_res", 32'(result), 32'd0);
    check("mrst_fn", 32'(alu_function), 32'(FN_HOLD));
    start_run(4'd8);
    wait_done(10, "lat_rst", adds, acts);
    check("mrst_slots", 32'(acts), 32'd0);
    check("mrst_res2", 32'(result), 32'd0);

    // random traffic, checked by the per-cycle compare
    for (int c = 0; c < 800; c++) begin
      @(negedge Clock);
      Reset_b   = ($urandom_range(0, 199) == 0);
      prog_we   = ($urandom_range(0, 2) == 0);
      prog_addr = 3'($urandom);
      prog_data = 4'($urandom);
      prog_func = 2'($urandom);
      prog_len  = 4'($urandom);
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 15) == 0);
    end
    @(negedge Clock);
    Reset_b = 0; prog_we = 0; start = 0; abort = 0;
    repeat (20) @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
